// File: rtl/breakout_score.sv
// breakout_score
// Score, lives and high-score bookkeeping for Breakout. All outputs are
// 4-bit BCD digits so they can drive HEX seven-segment encoders directly.
// A hit is added to the 3-digit score one digit per cycle. The score
// saturates at 999.
//
// Ports:
//   clk                  system clock, all state on the rising edge
//   reset                asynchronous active-low reset
//   new_game             synchronous restart pulse; highest priority
//   hit_valid/hit_ready  brick-hit handshake
//   hit_points[3:0]      binary points for a hit, clamped to 9
//   ball_lost            synchronous pulse; removes one life
//   score2..score0       committed score digits (hundreds, tens, ones)
//   high2..high0         high-score digits; cleared only by reset
//   lives_bcd            remaining lives, 0-9
//   game_over            high while lives_bcd == 0
module breakout_score #(
    parameter logic [3:0] START_LIVES = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       hit_valid,
    input  logic [3:0] hit_points,
    output logic       hit_ready,
    input  logic       ball_lost,
    output logic [3:0] score2,
    output logic [3:0] score1,
    output logic [3:0] score0,
    output logic [3:0] high2,
    output logic [3:0] high1,
    output logic [3:0] high0,
    output logic [3:0] lives_bcd,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, ADD0, ADD1, ADD2} state_t;

    state_t     state_q, state_d;
    logic [3:0] w2_q, w1_q, w0_q, w2_d, w1_d, w0_d;
    logic [3:0] p_q, p_d;
    logic       carry_q, carry_d;
    logic [3:0] score2_q, score1_q, score0_q, score2_d, score1_d, score0_d;
    logic [3:0] high2_q, high1_q, high0_q, high2_d, high1_d, high0_d;
    logic [3:0] lives_q, lives_d;

    logic [4:0] sum0, sum1, sum2;
    logic       accept;

    assign game_over = (lives_q == 4'd0);
    assign hit_ready = (state_q == IDLE) && !game_over;
    assign accept    = hit_valid && hit_ready;

    // Digit sums are one bit wider so the >9 decimal carry is visible.
    assign sum0 = {1'b0, w0_q} + {1'b0, p_q};
    assign sum1 = {1'b0, w1_q} + {4'b0000, carry_q};
    assign sum2 = {1'b0, w2_q} + {4'b0000, carry_q};

    always_comb begin
        state_d  = state_q;
        w2_d     = w2_q;
        w1_d     = w1_q;
        w0_d     = w0_q;
        p_d      = p_q;
        carry_d  = carry_q;
        score2_d = score2_q;
        score1_d = score1_q;
        score0_d = score0_q;
        high2_d  = high2_q;
        high1_d  = high1_q;
        high0_d  = high0_q;
        lives_d  = lives_q;

        case (state_q)
            IDLE: begin
                // BCD digits compare correctly as one packed binary word.
                if ({score2_q, score1_q, score0_q} > {high2_q, high1_q, high0_q}) begin
                    high2_d = score2_q;
                    high1_d = score1_q;
                    high0_d = score0_q;
                end
                if (accept) begin
                    p_d     = (hit_points > 4'd9) ? 4'd9 : hit_points;
                    w2_d    = score2_q;
                    w1_d    = score1_q;
                    w0_d    = score0_q;
                    state_d = ADD0;
                end
            end
            ADD0: begin
                // Subtracting 10 modulo 16 on the low nibble gives the
                // right digit for every sum in 10..18.
                carry_d = (sum0 > 5'd9);
                w0_d    = carry_d ? (sum0[3:0] - 4'd10) : sum0[3:0];
                state_d = ADD1;
            end
            ADD1: begin
                carry_d = (sum1 > 5'd9);
                w1_d    = carry_d ? (sum1[3:0] - 4'd10) : sum1[3:0];
                state_d = ADD2;
            end
            ADD2: begin
                // Only 9xx + carry can overflow the hundreds digit.
                if (sum2 > 5'd9) begin
                    score2_d = 4'd9;
                    score1_d = 4'd9;
                    score0_d = 4'd9;
                end else begin
                    score2_d = sum2[3:0];
                    score1_d = w1_q;
                    score0_d = w0_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ball_lost && (lives_q != 4'd0)) begin
            lives_d = lives_q - 4'd1;
        end

        // Restart overrides the adder and lives; the high score is kept.
        if (new_game) begin
            state_d  = IDLE;
            score2_d = 4'd0;
            score1_d = 4'd0;
            score0_d = 4'd0;
            lives_d  = START_LIVES;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            w2_q     <= 4'd0;
            w1_q     <= 4'd0;
            w0_q     <= 4'd0;
            p_q      <= 4'd0;
            carry_q  <= 1'b0;
            score2_q <= 4'd0;
            score1_q <= 4'd0;
            score0_q <= 4'd0;
            high2_q  <= 4'd0;
            high1_q  <= 4'd0;
            high0_q  <= 4'd0;
            lives_q  <= START_LIVES;
        end else begin
            state_q  <= state_d;
            w2_q     <= w2_d;
            w1_q     <= w1_d;
            w0_q     <= w0_d;
            p_q      <= p_d;
            carry_q  <= carry_d;
            score2_q <= score2_d;
            score1_q <= score1_d;
            score0_q <= score0_d;
            high2_q  <= high2_d;
            high1_q  <= high1_d;
            high0_q  <= high0_d;
            lives_q  <= lives_d;
        end
    end

    assign score2    = score2_q;
    assign score1    = score1_q;
    assign score0    = score0_q;
    assign high2     = high2_q;
    assign high1     = high1_q;
    assign high0     = high0_q;
    assign lives_bcd = lives_q;

endmodule

// File: tb/tb_breakout_score.sv
// Testbench for breakout_score: table of hits with expected scores, plus
// hand-written sequences for handshake timing, saturation, lives/game over,
// new_game abort and asynchronous reset in the middle of an add.
module tb_breakout_score;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic       hit_valid;
    logic [3:0] hit_points;
    logic       hit_ready;
    logic       ball_lost;
    logic [3:0] score2, score1, score0;
    logic [3:0] high2, high1, high0;
    logic [3:0] lives_bcd;
    logic       game_over;

    int n_chk  = 0;
    int n_fail = 0;

    breakout_score #(.START_LIVES(4'd3)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .hit_valid  (hit_valid),
        .hit_points (hit_points),
        .hit_ready  (hit_ready),
        .ball_lost  (ball_lost),
        .score2     (score2),
        .score1     (score1),
        .score0     (score0),
        .high2      (high2),
        .high1      (high1),
        .high0      (high0),
        .lives_bcd  (lives_bcd),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [11:0] score_v = {score2, score1, score0};
    wire [11:0] high_v  = {high2, high1, high0};

    typedef struct {
        logic [3:0]  pts;
        logic [11:0] exp_score;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for hit_ready, offers one hit, then waits through the
    // three add cycles and one more edge so the high score has settled.
    task automatic send_hit(input logic [3:0] pts);
        int k = 0;
        while (!hit_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hit_ready_wait", {11'd0, hit_ready}, 12'd1);
        hit_valid  = 1'b1;
        hit_points = pts;
        @(negedge clk);
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        new_game   = 1'b0;
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        ball_lost  = 1'b0;

        tbl[0] = '{4'd9,  12'h009};
        tbl[1] = '{4'd15, 12'h018};
        tbl[2] = '{4'd0,  12'h018};
        tbl[3] = '{4'd2,  12'h020};
        tbl[4] = '{4'd9,  12'h029};
        tbl[5] = '{4'd9,  12'h038};
        tbl[6] = '{4'd9,  12'h047};

        // Reset state
        do_reset();
        chk("rst_score",     score_v, 12'h000);
        chk("rst_high",      high_v,  12'h000);
        chk("rst_lives",     {8'd0, lives_bcd}, 12'd3);
        chk("rst_game_over", {11'd0, game_over}, 12'd0);
        chk("rst_hit_ready", {11'd0, hit_ready}, 12'd1);

        // Table of hits from 000 up to 047
        for (int i = 0; i < 7; i++) begin
            send_hit(tbl[i].pts);
            chk($sformatf("tbl_score_%0d", i), score_v, tbl[i].exp_score);
        end
        chk("tbl_high", high_v, 12'h047);

        // 047 + 5: handshake timing and commit / high-score edges
        hit_valid  = 1'b1;
        hit_points = 4'd5;
        @(negedge clk);                        // after E0
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        chk("e0_ready", {11'd0, hit_ready}, 12'd0);
        chk("e0_score", score_v, 12'h047);
        @(negedge clk);                        // after E1
        chk("e1_ready", {11'd0, hit_ready}, 12'd0);
        chk("e1_score", score_v, 12'h047);
        @(negedge clk);                        // after E2
        chk("e2_ready", {11'd0, hit_ready}, 12'd0);
        chk("e2_score", score_v, 12'h047);
        @(negedge clk);                        // after E3
        chk("e3_ready", {11'd0, hit_ready}, 12'd1);
        chk("e3_score", score_v, 12'h052);
        chk("e3_high",  high_v,  12'h047);
        @(negedge clk);                        // after E4
        chk("e4_high",  high_v,  12'h052);

        // Saturation at 999
        do_reset();
        for (int i = 0; i < 110; i++) send_hit(4'd9);
        send_hit(4'd5);
        chk("sat_995", score_v, 12'h995);
        send_hit(4'd9);
        chk("sat_999", score_v, 12'h999);
        send_hit(4'd15);
        chk("sat_hold", score_v, 12'h999);
        chk("sat_high", high_v,  12'h999);

        // Lives, game over, in-flight add completing
        do_reset();
        send_hit(4'd9);
        send_hit(4'd1);
        chk("lv_score_010", score_v, 12'h010);
        ball_lost = 1'b1;
        @(negedge clk);
        ball_lost = 1'b0;
        chk("lv_2", {8'd0, lives_bcd}, 12'd2);
        ball_lost = 1'b1;
        @(negedge clk);
        ball_lost = 1'b0;
        chk("lv_1",    {8'd0, lives_bcd}, 12'd1);
        chk("lv_go_0", {11'd0, game_over}, 12'd0);
        hit_valid  = 1'b1;
        hit_points = 4'd3;
        @(negedge clk);                        // after E0
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        ball_lost  = 1'b1;
        @(negedge clk);                        // after E1
        ball_lost  = 1'b0;
        chk("lv_0",        {8'd0, lives_bcd}, 12'd0);
        chk("lv_go_1",     {11'd0, game_over}, 12'd1);
        chk("lv_inflight", score_v, 12'h010);
        repeat (2) @(negedge clk);             // after E3
        chk("lv_commit_013", score_v, 12'h013);
        hit_valid  = 1'b1;
        hit_points = 4'd5;
        @(negedge clk);
        chk("go_ready_low", {11'd0, hit_ready}, 12'd0);
        repeat (6) @(negedge clk);
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        chk("go_score_013", score_v, 12'h013);
        ball_lost = 1'b1;
        @(negedge clk);
        ball_lost = 1'b0;
        chk("lv_stay_0", {8'd0, lives_bcd}, 12'd0);

        // new_game during ADD1 aborts the add
        do_reset();
        for (int i = 0; i < 13; i++) send_hit(4'd9);
        send_hit(4'd3);
        chk("ng_score_120", score_v, 12'h120);
        chk("ng_high_120",  high_v,  12'h120);
        ball_lost = 1'b1;
        @(negedge clk);
        ball_lost = 1'b0;
        chk("ng_lives_2", {8'd0, lives_bcd}, 12'd2);
        hit_valid  = 1'b1;
        hit_points = 4'd7;
        @(negedge clk);                        // after E0, state ADD0
        hit_valid  = 1'b0;
        @(negedge clk);                        // after E1, state ADD1
        new_game   = 1'b1;
        ball_lost  = 1'b1;
        hit_valid  = 1'b1;
        @(negedge clk);                        // after E2
        new_game   = 1'b0;
        ball_lost  = 1'b0;
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        chk("ng_score_0", score_v, 12'h000);
        chk("ng_lives_3", {8'd0, lives_bcd}, 12'd3);
        chk("ng_idle",    {11'd0, hit_ready}, 12'd1);
        repeat (3) @(negedge clk);
        chk("ng_no_commit", score_v, 12'h000);
        chk("ng_high_kept", high_v,  12'h120);

        // Asynchronous reset while in ADD2
        send_hit(4'd9);
        chk("ar_score_009", score_v, 12'h009);
        ball_lost = 1'b1;
        @(negedge clk);
        ball_lost  = 1'b0;
        hit_valid  = 1'b1;
        hit_points = 4'd4;
        @(negedge clk);                        // after E0
        hit_valid  = 1'b0;
        hit_points = 4'd0;
        @(negedge clk);                        // after E1
        @(negedge clk);                        // after E2, state ADD2
        #2 reset = 1'b0;
        #1;
        chk("ar_score", score_v, 12'h000);
        chk("ar_high",  high_v,  12'h000);
        chk("ar_lives", {8'd0, lives_bcd}, 12'd3);
        chk("ar_ready", {11'd0, hit_ready}, 12'd1);
        chk("ar_go",    {11'd0, game_over}, 12'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_no_commit", score_v, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/breakout_score.md
# breakout_score

Score and lives bookkeeping for the Breakout game, sitting directly upstream of the HEX-display encoders. It accepts brick-hit events carrying a point value and adds them to a 3-digit BCD score using one digit per cycle. It also tracks remaining lives and a running high score. All values leave as 4-bit BCD digits (0–9 only), so each one drives a HEX seven-segment encoder directly.

## Interface
- START_LIVES, 3, lives loaded on reset and on new_game (legal range 1–9)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- new_game  in  1  synchronous pulse, restarts the game
- hit_valid  in  1  brick-hit request
- hit_points  in  4  points for this hit, binary
- hit_ready  out  1  hit accepted on an edge where hit_valid & hit_ready
- ball_lost  in  1  synchronous pulse, one life lost
- score2, score1, score0  out  4 each  committed score BCD (hundreds, tens, ones)
- high2, high1, high0  out  4 each  high score BCD
- lives_bcd  out  4  remaining lives, 0–9
- game_over  out  1  high while lives_bcd == 0

## Operation
- Reset values:
  - score and high score: all digits 0
  - lives_bcd = START_LIVES
  - game_over = 0
  - FSM in IDLE, so hit_ready = 1
- FSM states: IDLE, ADD0, ADD1, ADD2.
  - hit_ready = (state == IDLE) & ~game_over.
  - IDLE -> ADD0 on an accepted hit:
    - capture p = min(hit_points, 9) into the work addend;
    - copy the committed score into the work digits w2..w0.
  - ADD0: w0 = w0 + p in BCD (sum > 9 → subtract 10, carry = 1).
  - ADD1: w1 = w1 + carry in BCD, updating carry.
  - ADD2: w2 = w2 + carry in BCD. If it still carries, saturate: w2..w0 = 9,9,9.
  - Commit: the score outputs load w2..w0 on the ADD2 edge. State returns to IDLE.
  - hit_points = 0 runs the full sequence with no score change.
  - The score never wraps: 999 + anything = 999.
- Score outputs change only at commit. Intermediate work digits are never visible.
- Lives:
  - ball_lost with lives_bcd > 0 decrements lives on that edge.
  - ball_lost is ignored when lives_bcd == 0.
  - Lives logic is independent of the adder FSM.
- game_over is combinational from lives_bcd == 0.
  - An add already in flight when lives reach 0 still completes and commits.
  - No new hit is accepted while game_over is high.
- High score: in IDLE, if the committed score > high score (3-digit BCD compare, most-significant digit first), high loads the score on the next edge. The high score survives new_game and clears only on reset.
- new_game has highest priority:
  - score → 0, lives → START_LIVES, FSM → IDLE;
  - any in-flight add is aborted without commit;
  - ball_lost and hit_valid on the same edge are ignored.
- A reset assertion mid-add returns all state to its reset values asynchronously.

## Timing
- Accepting edge E0. Work registers load at E0, ADD0 runs at E1, ADD1 at E2, ADD2 and commit at E3.
  - Score outputs show the new value after E3.
  - hit_ready is low for exactly 3 cycles (after E0 through E3).
  - The next hit can be accepted at E4.
- Back-to-back hits held on hit_valid: one accepted every 4 cycles.
- High score updates one edge after the commit, at E4, provided the FSM is IDLE.
  - An acceptance at E4 itself does not block the update, because the FSM is still IDLE during that cycle.
- ball_lost takes effect on the same edge it is sampled. game_over follows in the same cycle as the lives change.

## Test plan
- Reset, then release → score 000, high 000, lives 3, game_over 0, hit_ready 1.
- Score 047, hit 5 → hit_ready low 3 cycles, score 052 after E3, high 052 after E4. Score holds 047 at E1 and E2.
- Score 995, hit 9 → 999 (saturate). A further hit of 15 → clamped to 9, score stays 999.
- Three ball_lost pulses, one arriving during an in-flight hit of 3 from score 010:
  - lives go 3→2→1→0 and game_over rises;
  - the in-flight add still commits 013;
  - a subsequent hit_valid sees hit_ready 0 and the score stays 013;
  - a 4th ball_lost leaves lives at 0.
- new_game during ADD1 (score 120, hit 7) → score 000, lives 3, FSM IDLE next cycle, no commit; high unchanged at 120.
- Reset asserted in ADD2 → all outputs return to reset values immediately, with no clock edge required.
